slc3_mem_responder: RTL and testbench

- Memory-side responder for the SLC-3 active-low memory bus (CE/OE/WE/UB/LB) driven by the control unit.
- Serves one 16-bit word per access from on-chip storage, with a configurable read latency and write hold requirement.
- Sits between the datapath's MAR/MDR and storage, replacing the external SRAM for simulation and FPGA builds.

---
 rtl/slc3_mem_pkg.sv | 21 ++
 rtl/slc3_mem_array.sv | 38 +++
 rtl/slc3_mem_responder.sv | 151 +++++++++++++++
 tb/tb_slc3_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and helpers for the SLC-3 memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package slc3_mem_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_VALID = 3'd2,
      WR_WAIT  = 3'd3,
      WR_DONE  = 3'd4
   } mem_state_t;

   // Active-low bus lane enables -> active-high byte write enables {hi, lo}.
   function automatic logic [1:0] lane_be(input logic ub_n, input logic lb_n);
      return {~ub_n, ~lb_n};
   endfunction

endpackage

// File: rtl/slc3_mem_array.sv
// Single-port word RAM with byte write enables and an enabled, resettable read register.
// Latency: read data appears one edge after rd_en; writes land on the edge wr_be is set.
// Backpressure: none; the caller must not assert rd_en and wr_be in the same cycle.
//
// Ports:
//   Clk, Reset    - clock, synchronous active-low reset (read register only)
//   addr          - shared word address for reads and writes
//   wr_be/wr_data - byte write enables {[15:8],[7:0]} and write word
//   rd_en/rd_data - read strobe and registered read word
module slc3_mem_array
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        wr_be,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

   // Storage has no reset so contents survive Reset and the array maps to block RAM.
   always_ff @(posedge Clk) begin
      if (wr_be[1]) mem[addr][15:8] <= wr_data[15:8];
      if (wr_be[0]) mem[addr][7:0]  <= wr_data[7:0];
   end

   // Output register doubles as Data_from_mem: it only moves on a read strobe.
   always_ff @(posedge Clk) begin
      if (!Reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[addr];
   end

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 active-low CE/OE/WE/UB/LB bus, backed by on-chip RAM.
// Latency: read data valid READ_LAT edges after the first sampled read; write commits on the
//          edge sampling the WR_HOLD-th consecutive CE/WE-low cycle. Backpressure: none, the
//          bus master paces accesses; Data_valid tells it when Data_from_mem can be loaded.
//
// Ports: Clk, Reset (sync active-low); Mem_CE/OE/WE/UB/LB (active-low bus controls);
//        ADDR (word address); Data_to_mem (write word); Data_from_mem (registered read word);
//        Data_valid (read word matches current ADDR).
// Optional: define SLC3_MEM_COLLIDE_CHK_EN to add the sticky Mem_err collision flag.
module slc3_mem_responder
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 1,
   parameter int WR_HOLD  = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_CE,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic              Mem_UB,
   input  logic              Mem_LB,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [WORD_W-1:0] Data_to_mem,
   output logic [WORD_W-1:0] Data_from_mem,
   output logic              Data_valid
`ifdef SLC3_MEM_COLLIDE_CHK_EN
   ,
   output logic              Mem_err
`endif
);

   localparam logic [2:0] RD_LAST = 3'(READ_LAT);
   localparam logic [2:0] WR_LAST = 3'(WR_HOLD);

   mem_state_t        state, state_nx;
   logic [2:0]        cnt, cnt_nx;
   logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
   logic              wr_go, rd_go;
   logic              wr_req, rd_req;
   logic [1:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;

   // Write wins over read whenever both strobes are low.
   assign wr_req = ~Mem_CE & ~Mem_WE;
   assign rd_req = ~Mem_CE & ~Mem_OE & Mem_WE;

   // State register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         rd_addr <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         rd_addr <= rd_addr_nx;
      end
   end

   // Next-state logic. In WR_WAIT, cnt is the number of low cycles already seen, so the
   // commit fires on the edge that samples the WR_HOLD-th one (directly from IDLE when 1).
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      rd_addr_nx = rd_addr;
      wr_go      = 1'b0;
      rd_go      = 1'b0;
      case (state)
         IDLE, RD_WAIT, RD_VALID: begin
            if (wr_req) begin
               if (WR_LAST == 3'd1) begin
                  wr_go    = 1'b1;
                  state_nx = WR_DONE;
               end else begin
                  state_nx = WR_WAIT;
                  cnt_nx   = 3'd1;
               end
            end else if (!rd_req) begin
               state_nx = IDLE;
            end else if (state == IDLE || ADDR != rd_addr) begin
               // New read, or the address moved under an in-flight/held read: restart.
               state_nx   = RD_WAIT;
               cnt_nx     = 3'd1;
               rd_addr_nx = ADDR;
            end else if (state == RD_WAIT) begin
               if (cnt == RD_LAST) begin
                  rd_go    = 1'b1;
                  state_nx = RD_VALID;
               end else begin
                  cnt_nx = cnt + 3'd1;
               end
            end
         end
         WR_WAIT: begin
            if (!wr_req) begin
               state_nx = IDLE;
            end else if (cnt + 3'd1 == WR_LAST) begin
               wr_go    = 1'b1;
               state_nx = WR_DONE;
            end else begin
               cnt_nx = cnt + 3'd1;
            end
         end
         WR_DONE: begin
            // Parked until WE rises so a long WE pulse commits exactly once.
            if (!wr_req) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      Data_valid = (state == RD_VALID);
   end

   // A reset edge must not complete a pending write.
   assign ram_be   = (wr_go && Reset) ? lane_be(Mem_UB, Mem_LB) : 2'b00;
   assign ram_addr = wr_go ? ADDR : rd_addr;

   slc3_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .Clk     (Clk),
      .Reset   (Reset),
      .addr    (ram_addr),
      .wr_be   (ram_be),
      .wr_data (Data_to_mem),
      .rd_en   (rd_go),
      .rd_data (Data_from_mem)
   );

`ifdef SLC3_MEM_COLLIDE_CHK_EN
   logic [ADDR_W-1:0] addr_q;

   // addr_q is last cycle's ADDR, so in WR_WAIT a mismatch means ADDR moved mid-write.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Mem_err <= 1'b0;
         addr_q  <= '0;
      end else begin
         addr_q <= ADDR;
         if ((~Mem_CE & ~Mem_OE & ~Mem_WE) || (state == WR_WAIT && ADDR != addr_q))
            Mem_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_slc3_mem_responder.sv
module tb_slc3_mem_responder;

   localparam int AW  = 10;
   localparam int RL1 = 1;
   localparam int WH1 = 1;
   localparam int RL3 = 3;
   localparam int WH3 = 3;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          ce = 1'b1, oe = 1'b1, we = 1'b1, ub = 1'b1, lb = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [15:0]   din = '0;
   logic [15:0]   d1, d3;
   logic          v1, v3;
`ifdef SLC3_MEM_COLLIDE_CHK_EN
   logic          e1, e3;
   logic          err_exp = 1'b0;
`endif

   slc3_mem_responder #(.ADDR_W(AW), .READ_LAT(RL1), .WR_HOLD(WH1)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(we), .Mem_UB(ub),
      .Mem_LB(lb), .ADDR(addr), .Data_to_mem(din), .Data_from_mem(d1), .Data_valid(v1)
`ifdef SLC3_MEM_COLLIDE_CHK_EN
      , .Mem_err(e1)
`endif
   );

   slc3_mem_responder #(.ADDR_W(AW), .READ_LAT(RL3), .WR_HOLD(WH3)) u_dut3 (
      .Clk(Clk), .Reset(Reset), .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(we), .Mem_UB(ub),
      .Mem_LB(lb), .ADDR(addr), .Data_to_mem(din), .Data_from_mem(d3), .Data_valid(v3)
`ifdef SLC3_MEM_COLLIDE_CHK_EN
      , .Mem_err(e3)
`endif
   );

   always #5 Clk = ~Clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] m1 [0:31];
   logic [15:0] m3 [0:31];
   logic [15:0] last1 = 16'h0000;
   logic [15:0] last3 = 16'h0000;
   logic [15:0] old3;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic ubn, input logic lbn);
      logic [15:0] r;
      r = old;
      if (!ubn) r[15:8] = nw[15:8];
      if (!lbn) r[7:0]  = nw[7:0];
      return r;
   endfunction

   // run = consecutive sampled read edges on the current address (0 when not reading).
   // A read word is valid once READ_LAT edges have passed after the first one; otherwise
   // the output register holds whatever it last returned.
   task automatic check_outs(input string tag, input int run);
      logic e;
      e = (run >= RL1 + 1);
      chk({tag, "_valid1"}, {15'd0, v1}, {15'd0, e});
      if (e) last1 = m1[addr[4:0]];
      chk({tag, "_data1"}, d1, last1);
      e = (run >= RL3 + 1);
      chk({tag, "_valid3"}, {15'd0, v3}, {15'd0, e});
      if (e) last3 = m3[addr[4:0]];
      chk({tag, "_data3"}, d3, last3);
`ifdef SLC3_MEM_COLLIDE_CHK_EN
      chk({tag, "_err1"}, {15'd0, e1}, {15'd0, err_exp});
      chk({tag, "_err3"}, {15'd0, e3}, {15'd0, err_exp});
`endif
   endtask

   // Hold CE/WE low for n cycles; a DUT commits the data present on its WR_HOLD-th cycle.
   task automatic write_op(input logic [4:0] a, input logic [15:0] d0, input bit vary,
                           input logic ubn, input logic lbn, input int n, input logic oe_n);
      for (int i = 0; i < n; i++) begin
         ce = 1'b0; we = 1'b0; oe = oe_n; ub = ubn; lb = lbn;
         addr = {5'd0, a};
         din  = vary ? d0 + 16'(i) : d0;
         if (i == WH1 - 1) m1[a] = merge(m1[a], din, ubn, lbn);
         if (i == WH3 - 1) m3[a] = merge(m3[a], din, ubn, lbn);
`ifdef SLC3_MEM_COLLIDE_CHK_EN
         if (!oe_n) err_exp = 1'b1;
`endif
         tick();
         check_outs("wr", 0);
      end
      ce = 1'b1; we = 1'b1; oe = 1'b1; ub = 1'b1; lb = 1'b1;
      tick();
      check_outs("wr_end", 0);
   endtask

   // Read a for n cycles, then b for m cycles without releasing OE.
   task automatic read_op(input logic [4:0] a, input int n, input logic [4:0] b, input int m);
      int run;
      logic [4:0] cur;
      run = 0;
      for (int i = 0; i < n + m; i++) begin
         cur = (i < n) ? a : b;
         if (i == 0 || (i == n && b != a)) run = 1;
         else run++;
         ce = 1'b0; oe = 1'b0; we = 1'b1;
         addr = {5'd0, cur};
         tick();
         check_outs("rd", run);
      end
      ce = 1'b1; oe = 1'b1;
      tick();
      check_outs("rd_end", 0);
   endtask

   initial begin
      // Reset state.
      tick();
      tick();
      check_outs("reset", 0);
      Reset = 1'b1;
      tick();

      // Known contents for the address window used below.
      for (int i = 0; i < 32; i++)
         write_op(5'(i), 16'($urandom), 1'b0, 1'b0, 1'b0, 3, 1'b1);

      // Single-cycle write, then a two-cycle read on the READ_LAT=1 instance.
      write_op(5'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      read_op(5'd5, 2, 5'd5, 0);
      chk("beef_read", d1, 16'hBEEF);
      read_op(5'd5, 4, 5'd5, 0);

      // Byte lanes.
      write_op(5'd7, 16'h1234, 1'b0, 1'b0, 1'b0, 3, 1'b1);
      write_op(5'd7, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3, 1'b1);
      read_op(5'd7, 4, 5'd7, 0);
      chk("lane_lo1", d1, 16'h12A5);
      chk("lane_lo3", d3, 16'h12A5);
      write_op(5'd7, 16'hFF00, 1'b0, 1'b0, 1'b1, 3, 1'b1);
      read_op(5'd7, 4, 5'd7, 0);
      chk("lane_hi1", d1, 16'hFFA5);
      chk("lane_hi3", d3, 16'hFFA5);
      write_op(5'd7, 16'h0BAD, 1'b0, 1'b1, 1'b1, 3, 1'b1);
      read_op(5'd7, 4, 5'd7, 0);
      chk("lane_none1", d1, 16'hFFA5);

      // Long WE pulse with changing data: exactly one commit.
      write_op(5'd11, 16'h0001, 1'b1, 1'b0, 1'b0, 5, 1'b1);
      read_op(5'd11, 4, 5'd11, 0);
      chk("long_we1", d1, 16'h0001);
      chk("long_we3", d3, 16'h0003);

      // WE low shorter than WR_HOLD=3: no write on that instance.
      old3 = m3[12];
      write_op(5'd12, 16'h7777, 1'b0, 1'b0, 1'b0, 2, 1'b1);
      read_op(5'd12, 4, 5'd12, 0);
      chk("short_we1", d1, 16'h7777);
      chk("short_we3", d3, old3);

      // OE and WE low together: resolves as a write, no valid read.
      write_op(5'd9, 16'h0042, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      read_op(5'd9, 4, 5'd9, 0);
      chk("collide1", d1, 16'h0042);
      chk("collide3", d3, 16'h0042);

      // Address changes under held and in-flight reads.
      read_op(5'd3, 3, 5'd4, 5);
      read_op(5'd6, 2, 5'd8, 4);

      // Reset during a read: the READ_LAT=3 instance is still waiting.
      ce = 1'b0; oe = 1'b0; we = 1'b1; addr = {5'd0, 5'd2};
      tick();
      tick();
      Reset = 1'b0;
      last1 = 16'h0000;
      last3 = 16'h0000;
`ifdef SLC3_MEM_COLLIDE_CHK_EN
      err_exp = 1'b0;
`endif
      tick();
      check_outs("rst_rd", 0);
      chk("rst_rd_d3", d3, 16'h0000);
      ce = 1'b1; oe = 1'b1; Reset = 1'b1;
      tick();
      check_outs("rst_rd_rel", 0);

      // Reset on the edge that would commit a WR_HOLD=3 write.
      old3 = m3[13];
      ce = 1'b0; we = 1'b0; oe = 1'b1; ub = 1'b0; lb = 1'b0;
      addr = {5'd0, 5'd13}; din = 16'h5A5A;
      m1[13] = 16'h5A5A;
      tick();
      tick();
      Reset = 1'b0;
      tick();
      ce = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1; Reset = 1'b1;
      tick();
      check_outs("rst_wr", 0);
      read_op(5'd13, 4, 5'd13, 0);
      chk("rst_wr_abort3", d3, old3);
      chk("rst_wr_done1", d1, 16'h5A5A);

      // Random mix of writes, collisions and reads.
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(1) == 0)
            write_op(5'($urandom_range(31)), 16'($urandom), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(1, 5),
                     ($urandom_range(4) == 0) ? 1'b0 : 1'b1);
         else
            read_op(5'($urandom_range(31)), $urandom_range(1, 6),
                    5'($urandom_range(31)), $urandom_range(0, 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
